// File: rtl/capture_thresh_loader.sv
// Loads the load_thresh command word into the per-channel threshold table.
// Define THRESH_LOADER_READBACK_EN to compile the cmd 11 readback path onto rb_data.
module capture_thresh_loader #(
   parameter int                  CHAN_W       = 8,
   parameter int                  THRESH_W     = 16,
   parameter logic [THRESH_W-1:0] RESET_THRESH = 16'h8000
) (
   input  logic                user_clk,
   input  logic                user_rst,
   input  logic [31:0]         user_data_out,
   input  logic [CHAN_W-1:0]   rd_chan,
   output logic [THRESH_W-1:0] thresh_out,
   output logic                busy,
   output logic [15:0]         load_count,
   output logic [31:0]         rb_data
);

   localparam int DEPTH = 1 << CHAN_W;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      CHECK,
      WRITE,
      SWEEP
`ifdef THRESH_LOADER_READBACK_EN
      , READ
`endif
   } state_t;

   state_t state;
   state_t state_next;

   logic [31:0]         cmd_reg;
   logic                acc_tog;
   logic [CHAN_W-1:0]   sweep_addr;
   logic [THRESH_W-1:0] mem [DEPTH];

   logic [1:0]          cmd_op;
   logic [CHAN_W-1:0]   cmd_chan;
   logic [THRESH_W-1:0] cmd_thr;
   logic                pending;
   logic                stable;
   logic                sweep_last;

   logic                we;
   logic [CHAN_W-1:0]   waddr;
   logic [THRESH_W-1:0] wdata;
   logic                capture;
   logic                accept;
   logic                bump;
`ifdef THRESH_LOADER_READBACK_EN
   logic                rb_load;
`endif

   assign cmd_op     = cmd_reg[30:29];
   assign cmd_chan   = cmd_reg[16 +: CHAN_W];
   assign cmd_thr    = cmd_reg[THRESH_W-1:0];
   assign pending    = user_data_out[31] != acc_tog;
   assign stable     = user_data_out == cmd_reg;
   assign sweep_last = sweep_addr == CHAN_W'(DEPTH - 1);
   assign busy       = state != IDLE;

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state <= INIT;
      end else begin
         state <= state_next;
      end
   end

   // Next state plus the single write port; INIT and SWEEP share the address counter.
   always_comb begin
      state_next = state;
      we         = 1'b0;
      waddr      = sweep_addr;
      wdata      = RESET_THRESH;
      capture    = 1'b0;
      accept     = 1'b0;
      bump       = 1'b0;
`ifdef THRESH_LOADER_READBACK_EN
      rb_load    = 1'b0;
`endif
      case (state)
         INIT: begin
            we = 1'b1;
            if (sweep_last) begin
               state_next = IDLE;
            end
         end
         IDLE: begin
            if (pending) begin
               capture    = 1'b1;
               state_next = CHECK;
            end
         end
         CHECK: begin
            if (stable) begin
               accept = 1'b1;
               case (cmd_op)
                  2'b00:   state_next = WRITE;
                  2'b01:   state_next = SWEEP;
                  2'b10:   state_next = SWEEP;
`ifdef THRESH_LOADER_READBACK_EN
                  default: state_next = READ;
`else
                  default: state_next = IDLE;
`endif
               endcase
            end else begin
               capture = 1'b1;
            end
         end
         WRITE: begin
            we         = 1'b1;
            waddr      = cmd_chan;
            wdata      = cmd_thr;
            bump       = 1'b1;
            state_next = IDLE;
         end
         SWEEP: begin
            we    = 1'b1;
            wdata = (cmd_op == 2'b10) ? cmd_thr : RESET_THRESH;
            if (sweep_last) begin
               bump       = 1'b1;
               state_next = IDLE;
            end
         end
`ifdef THRESH_LOADER_READBACK_EN
         READ: begin
            rb_load    = 1'b1;
            bump       = 1'b1;
            state_next = IDLE;
         end
`endif
         default: begin
            state_next = INIT;
         end
      endcase
   end

   // While initialising, acc_tog tracks the live toggle so a stale command is never replayed.
   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         cmd_reg    <= '0;
         acc_tog    <= user_data_out[31];
         sweep_addr <= '0;
         load_count <= '0;
      end else begin
         if (state == INIT) begin
            acc_tog <= user_data_out[31];
         end else if (accept) begin
            acc_tog <= cmd_reg[31];
         end
         if (capture) begin
            cmd_reg <= user_data_out;
         end
         if (state == INIT || state == SWEEP) begin
            sweep_addr <= sweep_addr + 1'b1;
         end else begin
            sweep_addr <= '0;
         end
         if (bump) begin
            load_count <= load_count + 16'd1;
         end
      end
   end

   always_ff @(posedge user_clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Separate process from the write, so a same-address access returns the old entry.
   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         thresh_out <= '0;
      end else begin
         thresh_out <= mem[rd_chan];
      end
   end

`ifdef THRESH_LOADER_READBACK_EN
   logic [THRESH_W-1:0] fsm_rd_data;
   logic [12:0]         rb_chan;
   logic [15:0]         rb_thr;

   always_ff @(posedge user_clk) begin
      fsm_rd_data <= mem[cmd_chan];
   end

   always_comb begin
      rb_chan                = '0;
      rb_chan[CHAN_W-1:0]    = cmd_chan;
      rb_thr                 = 16'($signed(fsm_rd_data));
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         rb_data <= '0;
      end else if (rb_load) begin
         rb_data <= {acc_tog, 2'b11, rb_chan, rb_thr};
      end
   end
`else
   assign rb_data = '0;
`endif

endmodule
